imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory that the fetch stage reads. Accepts a byte stream over a valid/ready handshake, which may come from a UART receiver or a test host. The stream carries a little-endian word-count header followed by little-endian 32-bit instruction words. The block assembles the words and writes them sequentially from byte address 0 into the instruction memory write port. It holds the core in reset until the image is fully written, then releases it so fetch starts at PC 0.

## Interface
Parameters:
- ADDR_W, 8, word-address width of the instruction memory; capacity is 2**ADDR_W words.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- i_start  in  1  one-cycle request to begin a load
- i_byte_valid  in  1  stream byte present
- i_byte  in  8  stream byte
- o_byte_ready  out  1  block consumes i_byte this cycle if i_byte_valid
- o_we  out  1  instruction memory write strobe, one cycle per word
- o_waddr  out  32  byte write address, word aligned (bits [1:0] = 0)
- o_wdata  out  32  write data
- o_core_rst  out  1  active-high synchronous reset to the core pipeline (fetch `rst`)
- o_busy  out  1  load in progress
- o_done  out  1  image loaded, core released
- o_err  out  1  load aborted

## Operation
- A byte transfer occurs on a rising edge where i_byte_valid & o_byte_ready are both 1. Otherwise the byte is not consumed.
- FSM states: IDLE, LEN0, LEN1, DATA, CHK (macro only), DONE, ERR.
- IDLE: ready=0. On i_start, go to LEN0.
- LEN0: ready=1. The transferred byte becomes len[7:0]. Go to LEN1.
- LEN1: ready=1. The transferred byte becomes len[15:8].
  - If len > 2**ADDR_W, go to ERR.
  - Else if len == 0, go to DONE (CHK with macro).
  - Else clear the word index and byte counter and go to DATA.
- DATA: ready=1. A 2-bit byte counter places bytes into the word LSB first: byte k goes to bits [8k+7:8k].
  - On the 4th byte, o_we pulses next cycle with o_waddr = index*4 and o_wdata = {b3,b2,b1,b0}, then the index increments.
  - After word len-1 is accepted, go to DONE (CHK with macro).
- DONE: ready=0, o_done=1, o_core_rst=0. i_start restarts at LEN0 and reasserts o_core_rst.
- ERR: ready=0, o_err=1, o_core_rst=1. i_start restarts at LEN0. Words already written are not scrubbed.
- o_busy=1 in LEN0, LEN1, DATA, CHK.
- i_start is ignored in LEN0, LEN1, DATA, CHK.
- Word index width is ADDR_W+1. o_waddr upper bits are zero.

## Timing
- Reset (rst=0), asynchronous: state=IDLE, o_we=0, o_waddr=0, o_wdata=0, o_core_rst=1, o_busy=0, o_done=0, o_err=0, o_byte_ready=0.
- A partial word or length is discarded on reset. o_we never fires during or after reset until a new word completes.
- All outputs are registered. o_byte_ready is a decode of the state register.
- Write latency: o_we is high in the cycle immediately after the edge that accepted the 4th byte.
- Sustained throughput is 1 byte/cycle. There are no internal stalls in DATA.
- The transition into DONE occurs on the edge accepting the final byte. o_we for the last word and o_done=1 appear in the same cycle, and o_core_rst falls in that cycle.
- The memory commits the last word on the next edge, which is the core's first edge out of reset. Fetch reads address 0 first, so this is safe for len ≥ 2. For len = 1, fetch of address 0 coincides with the write. The instruction memory must therefore write-through, or the integrator accepts a one-cycle stale read.
- A valid gap of any length mid-word leaves the byte counter and partial word unchanged.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last data byte (or after LEN1 when len == 0), the FSM enters CHK with ready=1.
  - The transferred byte is compared with the 8-bit modulo-256 sum of all data bytes; the length bytes are excluded.
  - Equal goes to DONE; unequal goes to ERR.
  - o_we for the last word still fires, and o_core_rst stays 1 until DONE.
- Not defined: no CHK state. The FSM goes directly to DONE as described above, and no checksum hardware is present.

## Test plan
- Basic load, ADDR_W=8:
  - Stimulus: i_start, then bytes 02 00 13 00 00 00 93 00 10 00 back-to-back.
  - Response: o_we writes addr 0x0 = 0x00000013, then addr 0x4 = 0x00100093. o_done=1 and o_core_rst=0 in the cycle of the second write.
- Backpressure and gaps:
  - Stimulus: same stream with valid deasserted 3 cycles between every byte.
  - Response: identical writes, exactly 2 o_we pulses.
  - Also: bytes offered in IDLE or DONE are not consumed.
- Length bounds:
  - Header 00 01 (256 words) is accepted.
  - Header 01 01 (257) gives o_err=1, o_core_rst=1, no o_we.
  - Header 00 00 gives o_done with no writes (non-checksum build).
- Reset mid-word:
  - Stimulus: rst low asynchronously after 2 data bytes of word 1.
  - Response: outputs at reset values immediately.
  - Follow-up: a subsequent i_start load writes correct words from addr 0 with no stray o_we.
- Checksum, macro defined:
  - Stream 01 00 13 00 00 00 13 gives DONE.
  - Trailer 14 instead gives ERR with o_core_rst=1.
- Reload: i_start in DONE reasserts o_core_rst and overwrites memory from address 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words, writes them from address 0, then releases the core.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailing modulo-256 checksum byte that must match before the core is released.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_we,
    output logic [31:0] o_waddr,
    output logic [31:0] o_wdata,
    output logic        o_core_rst,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR} state_t;
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = CHK;
`else
    localparam state_t S_FIN = DONE;
`endif
    state_t          r_state;
    logic [15:0]     r_len;
    logic [ADDR_W:0] r_idx;
    logic [1:0]      r_cnt;
    logic [23:0]     r_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      r_sum;
`endif
    logic            w_xfer;
    logic [15:0]     w_len;
    logic            w_last;

    assign w_xfer       = i_byte_valid && o_byte_ready;
    assign w_len        = {i_byte, r_len[7:0]};
    assign w_last       = (17'(r_idx) + 17'd1) == {1'b0, r_len};
    assign o_byte_ready = r_state inside {LEN0, LEN1, DATA, CHK};
    assign o_busy       = r_state inside {LEN0, LEN1, DATA, CHK};
    assign o_done       = r_state == DONE;
    assign o_err        = r_state == ERR;
    assign o_core_rst   = r_state != DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_word  <= '0;
            o_we    <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            o_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: if (i_start) r_state <= LEN0;
                LEN0: if (w_xfer) begin
                    r_len[7:0] <= i_byte;
                    r_state    <= LEN1;
                end
                LEN1: if (w_xfer) begin
                    r_len   <= w_len;
                    r_idx   <= '0;
                    r_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_sum   <= '0;
`endif
                    r_state <= ({1'b0, w_len} > CAP) ? ERR : (w_len == 16'd0) ? S_FIN : DATA;
                end
                DATA: if (w_xfer) begin
                    r_cnt <= r_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_sum <= r_sum + i_byte;
`endif
                    if (r_cnt == 2'd3) begin
                        o_we    <= 1'b1;
                        o_waddr <= 32'({r_idx, 2'b00});
                        o_wdata <= {i_byte, r_word};
                        r_idx   <= r_idx + 1'b1;
                        if (w_last) r_state <= S_FIN;
                    end else begin
                        r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: if (w_xfer) r_state <= (i_byte == r_sum) ? DONE : ERR;
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte-stream loads checked every cycle against a stream-position model of the loader.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start, i_byte_valid;
    logic [7:0]  i_byte;
    logic        o_byte_ready, o_we, o_core_rst, o_busy, o_done, o_err;
    logic [31:0] o_waddr, o_wdata;

    int checks = 0;
    int fails  = 0;

    imem_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_byte_valid(i_byte_valid), .i_byte(i_byte),
        .o_byte_ready(o_byte_ready), .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
        .o_core_rst(o_core_rst), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;
    int          m_mode = M_IDLE;
    int          m_pos = 0, m_len = 0, m_taken = 0;
    logic [7:0]  m_sum = '0;
    logic [31:0] m_word = '0, m_addr = '0, m_data = '0;
    bit          m_we = 1'b0;

    logic [31:0] lg_addr[$], lg_data[$];
    bit          lg_done[$], lg_crst[$];

    task automatic chk1(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%0b expected=%0b t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, a, e, $time);
        end
    endtask

    // Model: outputs follow from how many bytes of the current image have been consumed.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = M_IDLE;
            m_we   = 1'b0;
            m_pos  = 0;
        end else begin
            m_we = 1'b0;
            if (m_mode != M_LOAD) begin
                if (i_start) begin
                    m_mode = M_LOAD;
                    m_pos  = 0;
                    m_sum  = '0;
                    m_word = '0;
                end
            end else if (i_byte_valid) begin
                m_taken++;
                if (m_pos == 0) m_len = int'(i_byte);
                else if (m_pos == 1) begin
                    m_len = m_len + 256 * int'(i_byte);
                    if (m_len > 256) m_mode = M_ERR;
`ifndef IMEM_LOADER_CHECKSUM_EN
                    else if (m_len == 0) m_mode = M_DONE;
`endif
                end else if (m_pos - 2 < 4 * m_len) begin
                    int k;
                    k = m_pos - 2;
                    m_word[8*(k%4) +: 8] = i_byte;
                    m_sum = m_sum + i_byte;
                    if (k % 4 == 3) begin
                        m_we   = 1'b1;
                        m_addr = 32'((k / 4) * 4);
                        m_data = m_word;
`ifndef IMEM_LOADER_CHECKSUM_EN
                        if (k / 4 == m_len - 1) m_mode = M_DONE;
`endif
                    end
                end else begin
                    m_mode = (i_byte == m_sum) ? M_DONE : M_ERR;
                end
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        chk1("ready", o_byte_ready, m_mode == M_LOAD);
        chk1("busy", o_busy, m_mode == M_LOAD);
        chk1("done", o_done, m_mode == M_DONE);
        chk1("err", o_err, m_mode == M_ERR);
        chk1("core_rst", o_core_rst, m_mode != M_DONE);
        chk1("we", o_we, m_we);
        if (m_we) begin
            chk32("waddr", o_waddr, m_addr);
            chk32("wdata", o_wdata, m_data);
        end
        if (o_we) begin
            lg_addr.push_back(o_waddr);
            lg_data.push_back(o_wdata);
            lg_done.push_back(o_done);
            lg_crst.push_back(o_core_rst);
        end
    end

    task automatic clear_log();
        lg_addr.delete(); lg_data.delete(); lg_done.delete(); lg_crst.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        i_byte_valid = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit noise);
        int tgt;
        bit ok;
        tgt = m_taken + 1;
        repeat (gap) begin
            @(negedge clk);
            i_byte_valid = 1'b0;
            i_start = 1'b0;
        end
        @(negedge clk);
        i_byte_valid = 1'b1;
        i_byte = b;
        i_start = noise && ($urandom_range(7, 0) == 0);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clk);
            #1;
            if (m_taken >= tgt) ok = 1'b1;
            else begin
                @(negedge clk);
                i_start = 1'b0;
            end
        end
        if (!ok) chk1("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic end_load();
        @(negedge clk);
        i_byte_valid = 1'b0;
        i_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_load(input logic [7:0] s[$], input int gmin, input int gmax, input bit noise);
        pulse_start();
        foreach (s[i]) send(s[i], int'($urandom_range(gmax, gmin)), noise);
        end_load();
    endtask

    task automatic offer_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_byte_valid = 1'b1;
            i_byte = 8'($urandom);
            #1 chk1("idle_ready", o_byte_ready, 1'b0);
        end
        @(negedge clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic check_basic(input string nm);
        chk32({nm, "_nwrites"}, 32'(lg_addr.size()), 32'd2);
        if (lg_addr.size() >= 2) begin
            chk32({nm, "_addr0"}, lg_addr[0], 32'h0);
            chk32({nm, "_data0"}, lg_data[0], 32'h0000_0013);
            chk32({nm, "_addr1"}, lg_addr[1], 32'h4);
            chk32({nm, "_data1"}, lg_data[1], 32'h0010_0093);
`ifndef IMEM_LOADER_CHECKSUM_EN
            chk1({nm, "_done_at_w1"}, lg_done[1], 1'b1);
            chk1({nm, "_crst_at_w1"}, lg_crst[1], 1'b0);
`endif
        end
        chk1({nm, "_done_end"}, o_done, 1'b1);
    endtask

    initial begin
        logic [7:0] basic[$];
        logic [7:0] s[$];
        logic [7:0] sum;
        int len;
        i_start = 1'b0;
        i_byte_valid = 1'b0;
        i_byte = 8'h00;
        basic = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        basic.push_back(8'hB6);
`endif
        #3;
        chk1("rst_core_rst", o_core_rst, 1'b1);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_we", o_we, 1'b0);
        chk1("rst_ready", o_byte_ready, 1'b0);
        chk1("rst_done", o_done, 1'b0);
        chk32("rst_waddr", o_waddr, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        offer_idle(4);

        clear_log();
        run_load(basic, 0, 0, 1'b0);
        check_basic("basic");

        clear_log();
        run_load(basic, 3, 3, 1'b0);
        check_basic("gaps");
        offer_idle(4);

        clear_log();
        s = '{8'h01, 8'h01};
        run_load(s, 0, 0, 1'b0);
        chk1("len257_err", o_err, 1'b1);
        chk1("len257_crst", o_core_rst, 1'b1);
        chk32("len257_nwrites", 32'(lg_addr.size()), 32'd0);

        clear_log();
        s = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        run_load(s, 0, 0, 1'b0);
        chk1("len0_done", o_done, 1'b1);
        chk32("len0_nwrites", 32'(lg_addr.size()), 32'd0);

        clear_log();
        pulse_start();
        send(8'h00, 0, 1'b0);
        send(8'h01, 0, 1'b0);
        chk1("len256_busy", o_busy, 1'b1);
        chk1("len256_noerr", o_err, 1'b0);
        sum = '0;
        for (int i = 0; i < 1024; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            sum = sum + b;
            send(b, 0, 1'b0);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(sum, 0, 1'b0);
`endif
        end_load();
        chk1("len256_done", o_done, 1'b1);
        chk32("len256_nwrites", 32'(lg_addr.size()), 32'd256);

        pulse_start();
        send(8'h02, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        send(8'h13, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        #1 rst = 1'b0;
        i_byte_valid = 1'b0;
        #1;
        chk1("midrst_core_rst", o_core_rst, 1'b1);
        chk1("midrst_busy", o_busy, 1'b0);
        chk1("midrst_ready", o_byte_ready, 1'b0);
        chk1("midrst_we", o_we, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_log();
        run_load(basic, 0, 0, 1'b0);
        check_basic("after_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
        s = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        run_load(s, 0, 0, 1'b0);
        chk1("chk_good_done", o_done, 1'b1);
        s = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
        run_load(s, 0, 0, 1'b0);
        chk1("chk_bad_err", o_err, 1'b1);
        chk1("chk_bad_crst", o_core_rst, 1'b1);
`endif

        repeat (25) begin
            clear_log();
            s.delete();
            if ($urandom_range(5, 0) == 0) begin
                len = int'($urandom_range(600, 257));
                s.push_back(8'(len));
                s.push_back(8'(len >> 8));
                run_load(s, 0, 2, 1'b1);
                chk1("rnd_big_err", o_err, 1'b1);
                chk32("rnd_big_nwrites", 32'(lg_addr.size()), 32'd0);
            end else begin
                len = int'($urandom_range(8, 1));
                s.push_back(8'(len));
                s.push_back(8'h00);
                sum = '0;
                for (int i = 0; i < 4 * len; i++) begin
                    s.push_back(8'($urandom));
                    sum = sum + s[s.size()-1];
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                s.push_back(sum);
`endif
                run_load(s, 0, 2, 1'b1);
                chk1("rnd_done", o_done, 1'b1);
                chk32("rnd_nwrites", 32'(lg_addr.size()), 32'(len));
            end
            if ($urandom_range(3, 0) == 0) offer_idle(3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
